// File: rtl/mem_ctrl_pkg.sv
// Shared codes for mem_ctrl: memory stage codes (common with mem), access sizes,
// FSM state encoding and the alignment rule used by MEM_CTRL_MISALIGN_CHECK_EN.
package mem_ctrl_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WAIT = 3'd2,
    S_WR   = 3'd3,
    S_DONE = 3'd4
  } state_e;

  // Any size code other than byte/half is handled as a full word.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SIZE_B:  return 1'b0;
      SIZE_H:  return addr_lo[0];
      default: return addr_lo != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Pipeline request/response and mem port bundle for mem_ctrl.
// Misalign flags exist only when MEM_CTRL_MISALIGN_CHECK_EN is defined.
interface mem_ctrl_if #(
  parameter int ADDR_WIDTH = 17,
  parameter int LEN        = 32
) ();
  import mem_ctrl_pkg::*;

  // req is held (with stable fields) until its done pulse; done is a single-cycle
  // pulse with the data output valid in that cycle. A dropped req still completes.
  logic                  if_req;
  logic [31:0]           if_addr;
  logic                  if_done;
  logic [LEN-1:0]        if_inst;
  logic                  ls_req;
  logic                  ls_we;
  logic [1:0]            ls_size;
  logic                  ls_signed;
  logic [31:0]           ls_addr;
  logic [LEN-1:0]        ls_wdata;
  logic                  ls_done;
  logic [LEN-1:0]        ls_rdata;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [LEN-1:0]        mem_wdata;
  logic [1:0]            mem_stage_state;
  logic [LEN-1:0]        mem_rdata;
  state_e                dbg_state;
`ifdef MEM_CTRL_MISALIGN_CHECK_EN
  logic                  if_misalign;
  logic                  ls_misalign;
`endif

  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_size, ls_signed, ls_addr, ls_wdata, mem_rdata,
    input  if_done, if_inst, ls_done, ls_rdata, mem_addr, mem_wdata, mem_stage_state, dbg_state
`ifdef MEM_CTRL_MISALIGN_CHECK_EN
    , input if_misalign, ls_misalign
`endif
  );

  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_size, ls_signed, ls_addr, ls_wdata, mem_rdata,
    output if_done, if_inst, ls_done, ls_rdata, mem_addr, mem_wdata, mem_stage_state, dbg_state
`ifdef MEM_CTRL_MISALIGN_CHECK_EN
    , output if_misalign, ls_misalign
`endif
  );

endinterface

// File: rtl/mem_ctrl_ls_align.sv
// Load extraction/extension and sub-word store merge for mem_ctrl; with
// MEM_CTRL_MISALIGN_CHECK_EN it also flags misaligned incoming requests.
module mem_ctrl_ls_align
  import mem_ctrl_pkg::*;
#(
  parameter int LEN = 32
) (
  input  logic [1:0]     size_i,
  input  logic           signed_i,
  input  logic [LEN-1:0] wdata_i,
  input  logic [LEN-1:0] rdata_i,
  output logic [LEN-1:0] load_o,
  output logic [LEN-1:0] merge_o
`ifdef MEM_CTRL_MISALIGN_CHECK_EN
  ,
  input  logic [1:0]     req_size_i,
  input  logic [1:0]     req_addr_lo_i,
  output logic           misalign_o
`endif
);

  always_comb begin
    load_o  = rdata_i;
    merge_o = wdata_i;
    case (size_i)
      SIZE_B: begin
        load_o  = {{(LEN-8){signed_i & rdata_i[7]}}, rdata_i[7:0]};
        merge_o = {rdata_i[LEN-1:8], wdata_i[7:0]};
      end
      SIZE_H: begin
        load_o  = {{(LEN-16){signed_i & rdata_i[15]}}, rdata_i[15:0]};
        merge_o = {rdata_i[LEN-1:16], wdata_i[15:0]};
      end
      default: begin
        load_o  = rdata_i;
        merge_o = wdata_i;
      end
    endcase
  end

`ifdef MEM_CTRL_MISALIGN_CHECK_EN
  assign misalign_o = is_misaligned(req_size_i, req_addr_lo_i);
`endif

endmodule

// File: rtl/mem_ctrl.sv
// Arbitrating IF/LS memory controller driving the single shared mem port.
// Define MEM_CTRL_MISALIGN_CHECK_EN to reject misaligned requests.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 17,
  parameter int LEN        = 32
) (
  input logic     clk,
  input logic     rst,
  mem_ctrl_if.slave bus
);

  state_e                state_q;
  logic                  is_ls_q, we_q, signed_q;
  logic [1:0]            size_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN-1:0]        wdata_q, mem_wdata_q, if_inst_q, ls_rdata_q;
  logic                  if_done_q, ls_done_q;

  logic [LEN-1:0]        load_data, merge_word;
  logic [1:0]            req_size;
  logic [31:0]           req_addr;
  logic                  req_word_store;
  logic                  reject;

  // LS wins whenever both request; a waiting fetch is picked up on the next idle cycle.
  assign req_size       = bus.ls_req ? bus.ls_size : SIZE_W;
  assign req_addr       = bus.ls_req ? bus.ls_addr : bus.if_addr;
  assign req_word_store = bus.ls_req && bus.ls_we &&
                          (bus.ls_size != SIZE_B) && (bus.ls_size != SIZE_H);

`ifdef MEM_CTRL_MISALIGN_CHECK_EN
  logic if_mis_q, ls_mis_q;
  mem_ctrl_ls_align #(.LEN(LEN)) u_ls_align (
    .size_i        (size_q),
    .signed_i      (signed_q),
    .wdata_i       (wdata_q),
    .rdata_i       (bus.mem_rdata),
    .load_o        (load_data),
    .merge_o       (merge_word),
    .req_size_i    (req_size),
    .req_addr_lo_i (req_addr[1:0]),
    .misalign_o    (reject)
  );
  assign bus.if_misalign = if_mis_q;
  assign bus.ls_misalign = ls_mis_q;
`else
  mem_ctrl_ls_align #(.LEN(LEN)) u_ls_align (
    .size_i   (size_q),
    .signed_i (signed_q),
    .wdata_i  (wdata_q),
    .rdata_i  (bus.mem_rdata),
    .load_o   (load_data),
    .merge_o  (merge_word)
  );
  assign reject = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      is_ls_q     <= 1'b0;
      we_q        <= 1'b0;
      signed_q    <= 1'b0;
      size_q      <= SIZE_W;
      addr_q      <= '0;
      wdata_q     <= '0;
      mem_wdata_q <= '0;
      if_inst_q   <= '0;
      ls_rdata_q  <= '0;
      if_done_q   <= 1'b0;
      ls_done_q   <= 1'b0;
`ifdef MEM_CTRL_MISALIGN_CHECK_EN
      if_mis_q    <= 1'b0;
      ls_mis_q    <= 1'b0;
`endif
    end else begin
      if_done_q <= 1'b0;
      ls_done_q <= 1'b0;
`ifdef MEM_CTRL_MISALIGN_CHECK_EN
      if_mis_q  <= 1'b0;
      ls_mis_q  <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (bus.ls_req || bus.if_req) begin
            is_ls_q  <= bus.ls_req;
            we_q     <= bus.ls_req && bus.ls_we;
            size_q   <= req_size;
            signed_q <= bus.ls_signed;
            addr_q   <= req_addr[ADDR_WIDTH-1:0];
            wdata_q  <= bus.ls_wdata;
            if (reject) begin
              state_q <= S_DONE;
              if (bus.ls_req) begin
                ls_done_q  <= 1'b1;
                ls_rdata_q <= '0;
              end else begin
                if_done_q <= 1'b1;
                if_inst_q <= '0;
              end
`ifdef MEM_CTRL_MISALIGN_CHECK_EN
              ls_mis_q <= bus.ls_req;
              if_mis_q <= !bus.ls_req;
`endif
            end else if (req_word_store) begin
              mem_wdata_q <= bus.ls_wdata;
              state_q     <= S_WR;
            end else begin
              state_q <= S_RD;
            end
          end
        end
        S_RD: state_q <= S_WAIT;
        S_WAIT: begin
          // mem_rdata now holds the word read in S_RD.
          if (we_q) begin
            mem_wdata_q <= merge_word;
            state_q     <= S_WR;
          end else begin
            if (is_ls_q) begin
              ls_rdata_q <= load_data;
              ls_done_q  <= 1'b1;
            end else begin
              if_inst_q <= bus.mem_rdata;
              if_done_q <= 1'b1;
            end
            state_q <= S_DONE;
          end
        end
        S_WR: begin
          ls_done_q <= 1'b1;
          state_q   <= S_DONE;
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.mem_stage_state = (state_q == S_RD) ? READ :
                               (state_q == S_WR) ? WRITE : IDLE;
  assign bus.mem_addr        = addr_q;
  assign bus.mem_wdata       = mem_wdata_q;
  assign bus.if_done         = if_done_q;
  assign bus.if_inst         = if_inst_q;
  assign bus.ls_done         = ls_done_q;
  assign bus.ls_rdata        = ls_rdata_q;
  assign bus.dbg_state       = state_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: byte-array mem device, transaction-level reference model
// producing a per-cycle expected queue, one compare process, directed literal pins.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  localparam int AW = 17;
  localparam int N  = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  mem_ctrl_if #(.ADDR_WIDTH(AW), .LEN(32)) bus ();
  mem_ctrl #(.ADDR_WIDTH(AW), .LEN(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  // ---------------- mem device (registered read, no reset) ----------------
  logic [7:0] dev_mem [N];
  logic [7:0] ref_mem [N];

  always @(posedge clk) begin
    if (bus.mem_stage_state == READ)
      for (int k = 0; k < 4; k++) bus.mem_rdata[8*k +: 8] <= dev_mem[AW'(bus.mem_addr + k)];
    if (bus.mem_stage_state == WRITE)
      for (int k = 0; k < 4; k++) dev_mem[AW'(bus.mem_addr + k)] <= bus.mem_wdata[8*k +: 8];
  end

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [1:0]    stage;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic          ifd;
    logic          lsd;
    logic          chk;
    logic [31:0]   data;
    logic          mis;
  } exp_t;

  exp_t exp_q[$];

  function automatic exp_t mk(input logic [1:0] st, input logic [AW-1:0] a, input logic [31:0] wd,
                              input logic ifd, input logic lsd, input logic ck,
                              input logic [31:0] d, input logic mis);
    exp_t e;
    e.stage = st; e.addr = a; e.wdata = wd; e.ifd = ifd; e.lsd = lsd;
    e.chk = ck; e.data = d; e.mis = mis;
    return e;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [AW-1:0] a);
    logic [31:0] v;
    for (int k = 0; k < 4; k++) v[8*k +: 8] = ref_mem[AW'(a + k)];
    return v;
  endfunction

  task automatic ref_wr(input logic [AW-1:0] a, input logic [31:0] v);
    for (int k = 0; k < 4; k++) ref_mem[AW'(a + k)] = v[8*k +: 8];
  endtask

  task automatic poke(input int unsigned a, input logic [7:0] b);
    dev_mem[AW'(a)] = b;
    ref_mem[AW'(a)] = b;
  endtask

  task automatic model_ls(input bit we, input logic [1:0] sz, input bit sg,
                          input logic [31:0] la, input logic [31:0] wd);
    logic [AW-1:0] a;
    logic [31:0] old, v;
    int unsigned lo;
    a = la[AW-1:0];
`ifdef MEM_CTRL_MISALIGN_CHECK_EN
    if ((sz == SIZE_H && la[0]) || (sz == SIZE_W && la[1:0] != 2'b00)) begin
      exp_q.push_back(mk(IDLE, '0, '0, 1'b0, 1'b1, 1'b1, 32'h0, 1'b1));
      return;
    end
`endif
    old = ref_rd(a);
    if (!we) begin
      if (sz == SIZE_B) begin
        lo = old & 32'hFF;
        v  = (sg && lo >= 128) ? lo - 256 : lo;
      end else if (sz == SIZE_H) begin
        lo = old & 32'hFFFF;
        v  = (sg && lo >= 32768) ? lo - 65536 : lo;
      end else begin
        v = old;
      end
      exp_q.push_back(mk(READ, a, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0));
      exp_q.push_back(mk(IDLE, '0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0));
      exp_q.push_back(mk(IDLE, '0, '0, 1'b0, 1'b1, 1'b1, v, 1'b0));
    end else if (sz == SIZE_W) begin
      ref_wr(a, wd);
      exp_q.push_back(mk(WRITE, a, wd, 1'b0, 1'b0, 1'b0, '0, 1'b0));
      exp_q.push_back(mk(IDLE, '0, '0, 1'b0, 1'b1, 1'b0, '0, 1'b0));
    end else begin
      if (sz == SIZE_B) v = (old & 32'hFFFF_FF00) | (wd & 32'hFF);
      else              v = (old & 32'hFFFF_0000) | (wd & 32'hFFFF);
      ref_wr(a, v);
      exp_q.push_back(mk(READ, a, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0));
      exp_q.push_back(mk(IDLE, '0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0));
      exp_q.push_back(mk(WRITE, a, v, 1'b0, 1'b0, 1'b0, '0, 1'b0));
      exp_q.push_back(mk(IDLE, '0, '0, 1'b0, 1'b1, 1'b0, '0, 1'b0));
    end
  endtask

  task automatic model_if(input logic [31:0] ia);
    logic [AW-1:0] a;
    a = ia[AW-1:0];
`ifdef MEM_CTRL_MISALIGN_CHECK_EN
    if (ia[1:0] != 2'b00) begin
      exp_q.push_back(mk(IDLE, '0, '0, 1'b1, 1'b0, 1'b1, 32'h0, 1'b1));
      return;
    end
`endif
    exp_q.push_back(mk(READ, a, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0));
    exp_q.push_back(mk(IDLE, '0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0));
    exp_q.push_back(mk(IDLE, '0, '0, 1'b1, 1'b0, 1'b1, ref_rd(a), 1'b0));
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : mk(IDLE, '0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
      chk("mem_stage_state", 32'(bus.mem_stage_state), 32'(e.stage));
      if (e.stage != IDLE) chk("mem_addr", 32'(bus.mem_addr), 32'(e.addr));
      if (e.stage == WRITE) chk("mem_wdata", bus.mem_wdata, e.wdata);
      chk("if_done", 32'(bus.if_done), 32'(e.ifd));
      chk("ls_done", 32'(bus.ls_done), 32'(e.lsd));
      if (e.ifd && e.chk) chk("if_inst", bus.if_inst, e.data);
      if (e.lsd && e.chk) chk("ls_rdata", bus.ls_rdata, e.data);
`ifdef MEM_CTRL_MISALIGN_CHECK_EN
      chk("if_misalign", 32'(bus.if_misalign), 32'(e.ifd & e.mis));
      chk("ls_misalign", 32'(bus.ls_misalign), 32'(e.lsd & e.mis));
`endif
    end
  end

  // ---------------- driver ----------------
  logic [31:0] last_ls, last_if;
  int ls_cyc, if_cyc, iss_cyc;

  task automatic run_txn(input bit do_if, input logic [31:0] ia,
                         input bit do_ls, input bit we, input logic [1:0] sz, input bit sg,
                         input logic [31:0] la, input logic [31:0] wd, input bit drop);
    bit ls_pend, if_pend;
    @(negedge clk);
    if (do_ls) model_ls(we, sz, sg, la, wd);
    if (do_ls && do_if) exp_q.push_back(mk(IDLE, '0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0));
    if (do_if) model_if(ia);
    bus.if_req = do_if; bus.if_addr = ia;
    bus.ls_req = do_ls; bus.ls_we = we; bus.ls_size = sz; bus.ls_signed = sg;
    bus.ls_addr = la; bus.ls_wdata = wd;
    iss_cyc = cyc;
    ls_pend = do_ls;
    if_pend = do_if;
    for (int k = 0; k < 30 && (ls_pend || if_pend); k++) begin
      @(negedge clk);
      if (ls_pend && bus.ls_done) begin
        ls_pend = 1'b0; bus.ls_req = 1'b0; last_ls = bus.ls_rdata; ls_cyc = cyc;
      end
      if (if_pend && bus.if_done) begin
        if_pend = 1'b0; bus.if_req = 1'b0; last_if = bus.if_inst; if_cyc = cyc;
      end
      if (drop && k == 0) bus.ls_req = 1'b0;
    end
    if (ls_pend || if_pend) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: got no done pulse within 30 cycles, required one (cycle %0d)", cyc);
      bus.if_req = 1'b0;
      bus.ls_req = 1'b0;
      exp_q.delete();
    end
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom;
    if ($urandom_range(0, 3) == 0) a[AW-1:0] = AW'(32'h1FFFC + $urandom_range(0, 3));
    else                           a[AW-1:0] = AW'($urandom_range(0, 63));
    return a;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] b;
    logic [1:0] sz;
    int kind;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.ls_req = 1'b0; bus.ls_we = 1'b0; bus.ls_size = SIZE_W; bus.ls_signed = 1'b0;
    bus.ls_addr = '0; bus.ls_wdata = '0;
    for (int i = 0; i < N; i++) begin
      b = 8'($urandom);
      dev_mem[i] = b;
      ref_mem[i] = b;
    end

    repeat (3) @(negedge clk);
    chk("rst_stage", 32'(bus.mem_stage_state), 32'(IDLE));
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'h0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
    chk("rst_if_inst", bus.if_inst, 32'h0);
    chk("rst_ls_rdata", bus.ls_rdata, 32'h0);
    rst = 1'b0;

    poke(32'h100, 8'h78); poke(32'h101, 8'h56); poke(32'h102, 8'h34); poke(32'h103, 8'h12);
    poke(32'h104, 8'hEF); poke(32'h105, 8'hBE);
    poke(32'h200, 8'h80);
    poke(32'h300, 8'hDD); poke(32'h301, 8'hCC); poke(32'h302, 8'hBB); poke(32'h303, 8'hAA);

    run_txn(1'b0, '0, 1'b1, 1'b0, SIZE_W, 1'b0, 32'h0000_0100, '0, 1'b0);
    chk("word_load_lit", last_ls, 32'h1234_5678);
    chk("word_load_latency", 32'(ls_cyc - iss_cyc), 32'd3);

    run_txn(1'b0, '0, 1'b1, 1'b0, SIZE_B, 1'b1, 32'hFFFE_0200, '0, 1'b0);
    chk("byte_signed_lit", last_ls, 32'hFFFF_FF80);
    run_txn(1'b0, '0, 1'b1, 1'b0, SIZE_B, 1'b0, 32'h0000_0200, '0, 1'b0);
    chk("byte_unsigned_lit", last_ls, 32'h0000_0080);

    run_txn(1'b0, '0, 1'b1, 1'b1, SIZE_H, 1'b0, 32'h0000_0300, 32'h5555_1234, 1'b0);
    chk("half_store_latency", 32'(ls_cyc - iss_cyc), 32'd4);
    chk("half_store_mem_lit", {dev_mem[AW'(32'h303)], dev_mem[AW'(32'h302)],
                               dev_mem[AW'(32'h301)], dev_mem[AW'(32'h300)]}, 32'hAABB_1234);
    run_txn(1'b0, '0, 1'b1, 1'b0, SIZE_W, 1'b0, 32'h0000_0300, '0, 1'b0);
    chk("half_store_readback_lit", last_ls, 32'hAABB_1234);

    run_txn(1'b1, 32'h0000_0100, 1'b1, 1'b0, SIZE_W, 1'b0, 32'h0000_0300, '0, 1'b0);
    chk("arb_ls_lit", last_ls, 32'hAABB_1234);
    chk("arb_if_lit", last_if, 32'h1234_5678);
    chk("arb_if_gap", 32'(if_cyc - ls_cyc), 32'd4);

    run_txn(1'b0, '0, 1'b1, 1'b0, SIZE_W, 1'b0, 32'h0000_0102, '0, 1'b0);
`ifdef MEM_CTRL_MISALIGN_CHECK_EN
    chk("misalign_word_lit", last_ls, 32'h0);
    chk("misalign_latency", 32'(ls_cyc - iss_cyc), 32'd1);
`else
    chk("misalign_word_lit", last_ls, 32'hBEEF_1234);
    chk("misalign_latency", 32'(ls_cyc - iss_cyc), 32'd3);
`endif

    // Reset lands in cycle 2 of a load: no done, idle right after, fresh request works.
    @(negedge clk);
    exp_q.push_back(mk(READ, AW'(32'h100), '0, 1'b0, 1'b0, 1'b0, '0, 1'b0));
    exp_q.push_back(mk(IDLE, '0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0));
    exp_q.push_back(mk(IDLE, '0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0));
    bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_size = SIZE_W; bus.ls_addr = 32'h100;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.ls_req = 1'b0;
    chk("rst_mid_stage", 32'(bus.mem_stage_state), 32'(IDLE));
    chk("rst_mid_ls_rdata", bus.ls_rdata, 32'h0);
    run_txn(1'b0, '0, 1'b1, 1'b0, SIZE_W, 1'b0, 32'h0000_0100, '0, 1'b0);
    chk("after_rst_load_lit", last_ls, 32'h1234_5678);

    for (int i = 0; i < 200; i++) begin
      kind = $urandom_range(0, 9);
      sz   = 2'($urandom_range(0, 2));
      if (kind < 2)
        run_txn(1'b1, rand_addr(), 1'b0, 1'b0, SIZE_W, 1'b0, '0, '0, 1'b0);
      else if (kind < 8)
        run_txn(1'b0, '0, 1'b1, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
                rand_addr(), $urandom, ($urandom_range(0, 4) == 0));
      else
        run_txn(1'b1, rand_addr(), 1'b1, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
                rand_addr(), $urandom, 1'b0);
    end

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
